alu_exec_unit: RTL and testbench

//  Execute-stage ALU consuming the 3-bit alu_control code produced by the control block's ALU decoder.

---
 rtl/alu_exec_unit.sv | 135 +++++++++++++
 tb/tb_alu_exec_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Add/sub/and/or/slt finish in one cycle; shifts walk one bit per cycle.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_alu_control,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    state_t             state;
    logic [2:0]         op_q;
    logic [XLEN-1:0]    work_q;
    logic [SHAMT_W-1:0] count_q;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    first_shift;
    logic [XLEN-1:0]    next_work;

    function automatic logic [XLEN-1:0] shift_once(input logic [2:0] op,
                                                   input logic [XLEN-1:0] val);
        logic [XLEN-1:0] res;
        res = val;
        case (op)
            ALU_SLL: res = {val[XLEN-2:0], 1'b0};
            ALU_SRL: res = {1'b0, val[XLEN-1:1]};
            ALU_SRA: res = {val[XLEN-1], val[XLEN-1:1]};
            default: res = val;
        endcase
        return res;
    endfunction

    assign o_ready     = (state == IDLE);
    assign shamt       = i_src_b[SHAMT_W-1:0];
    assign is_shift    = (i_alu_control == ALU_SLL) || (i_alu_control == ALU_SRL) ||
                         (i_alu_control == ALU_SRA);
    assign first_shift = shift_once(i_alu_control, i_src_a);
    assign next_work   = shift_once(op_q, work_q);

    // Shift codes fall through to A, which is the correct result for shamt 0.
    always_comb begin
        alu_result = i_src_a;
        case (i_alu_control)
            ALU_ADD: alu_result = i_src_a + i_src_b;
            ALU_SUB: alu_result = i_src_a - i_src_b;
            ALU_AND: alu_result = i_src_a & i_src_b;
            ALU_OR:  alu_result = i_src_a | i_src_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(i_src_a) < $signed(i_src_b))};
            default: alu_result = i_src_a;
        endcase
    end

    // The first shift step happens at accept, so a k-bit shift is visible k cycles later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            work_q   <= '0;
            count_q  <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_q <= i_alu_control;
                        if (!is_shift || shamt == '0) begin
                            o_result <= alu_result;
                            o_zero   <= ~|alu_result;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else if (shamt == SHAMT_W'(1)) begin
                            o_result <= first_shift;
                            o_zero   <= ~|first_shift;
                            o_valid  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            work_q  <= first_shift;
                            count_q <= shamt - SHAMT_W'(1);
                            state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q  <= next_work;
                    count_q <= count_q - SHAMT_W'(1);
                    if (count_q == SHAMT_W'(1)) begin
                        o_result <= next_work;
                        o_zero   <= ~|next_work;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: one-cycle ops, serial shifts,
// result back-pressure and asynchronous reset during a shift.
module tb_alu_exec_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_alu_control;
    logic [31:0] i_src_a;
    logic [31:0] i_src_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;

    int checks;
    int errors;

    alu_exec_unit dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_alu_control (i_alu_control),
        .i_src_a       (i_src_a),
        .i_src_b       (i_src_b),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_zero        (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request and waits (bounded) for the result; leaves the DUT in DONE.
    task automatic applyStimulus(input string tag, input logic [2:0] code,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input int exp_lat, input logic [31:0] exp_res,
                                 input logic exp_zero);
        int lat;
        @(negedge i_clk);
        checkOutput({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        i_valid       = 1'b1;
        i_alu_control = code;
        i_src_a       = a;
        i_src_b       = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_src_a = ~a;
        i_src_b = ~b;
        lat = 1;
        while (!o_valid && lat < 40) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        checkOutput({tag, "_lat"},  lat, exp_lat);
        checkOutput({tag, "_res"},  o_result, exp_res);
        checkOutput({tag, "_zero"}, {31'd0, o_zero}, {31'd0, exp_zero});
    endtask

    task automatic drainResult(input string tag);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        checkOutput({tag, "_drain_valid"}, {31'd0, o_valid}, 32'd0);
        checkOutput({tag, "_drain_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held_res;
        checks        = 0;
        errors        = 0;
        i_rst_n       = 1'b0;
        i_valid       = 1'b0;
        i_ready       = 1'b0;
        i_alu_control = 3'b000;
        i_src_a       = '0;
        i_src_b       = '0;

        #12;
        checkOutput("rst_ready",  {31'd0, o_ready}, 32'd1);
        checkOutput("rst_valid",  {31'd0, o_valid}, 32'd0);
        checkOutput("rst_result", o_result, 32'd0);
        checkOutput("rst_zero",   {31'd0, o_zero},  32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        applyStimulus("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1'b0);
        drainResult("add_ovf");
        applyStimulus("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1);
        drainResult("add_wrap");
        applyStimulus("sub_zero", 3'b001, 32'd5, 32'd5, 1, 32'h0, 1'b1);
        drainResult("sub_zero");
        applyStimulus("slt_neg",  3'b101, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 1'b0);
        drainResult("slt_neg");
        applyStimulus("slt_pos",  3'b101, 32'h1, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
        drainResult("slt_pos");
        applyStimulus("and",      3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0);
        drainResult("and");
        applyStimulus("or",       3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 1'b0);
        drainResult("or");

        applyStimulus("sll31",    3'b100, 32'h1, 32'd31, 31, 32'h8000_0000, 1'b0);
        drainResult("sll31");
        applyStimulus("sll0",     3'b100, 32'h1234, 32'h20, 1, 32'h1234, 1'b0);
        drainResult("sll0");
        applyStimulus("sra4",     3'b111, 32'h8000_0000, 32'd4, 4, 32'hF800_0000, 1'b0);
        drainResult("sra4");
        applyStimulus("srl4",     3'b110, 32'h8000_0000, 32'd4, 4, 32'h0800_0000, 1'b0);
        drainResult("srl4");
        applyStimulus("srl1_hib", 3'b110, 32'h8000_0001, 32'hFFFF_FFE1, 1, 32'h4000_0000, 1'b0);
        drainResult("srl1_hib");
        applyStimulus("srl1_z",   3'b110, 32'h1, 32'hFFFF_FFE1, 1, 32'h0, 1'b1);
        drainResult("srl1_z");

        // Back-pressure: result must hold while new requests are offered.
        applyStimulus("hold", 3'b000, 32'd100, 32'd23, 1, 32'd123, 1'b0);
        held_res = 32'd123;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_valid       = i[0];
            i_alu_control = 3'(i);
            i_src_a       = 32'hDEAD_0000 + 32'(i);
            i_src_b       = 32'h0000_BEEF;
            @(posedge i_clk);
            #1;
            checkOutput("hold_valid",  {31'd0, o_valid}, 32'd1);
            checkOutput("hold_ready",  {31'd0, o_ready}, 32'd0);
            checkOutput("hold_result", o_result, held_res);
            checkOutput("hold_zero",   {31'd0, o_zero}, 32'd0);
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        drainResult("hold");
        @(posedge i_clk);
        #1;
        checkOutput("hold_idle_valid", {31'd0, o_valid}, 32'd0);

        // Asynchronous reset ten cycles into a 20-bit shift.
        @(negedge i_clk);
        i_valid       = 1'b1;
        i_alu_control = 3'b100;
        i_src_a       = 32'h1;
        i_src_b       = 32'd20;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
        end
        checkOutput("mid_shift_ready", {31'd0, o_ready}, 32'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("abort_valid",  {31'd0, o_valid}, 32'd0);
        checkOutput("abort_ready",  {31'd0, o_ready}, 32'd1);
        checkOutput("abort_result", o_result, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus("post_rst_add", 3'b000, 32'd2, 32'd3, 1, 32'd5, 1'b0);
        drainResult("post_rst_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
